// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//
// Execute stage of the 8-bit MCU datapath. It takes the two register-file read
// operands, runs one of eight operations and produces the register-file
// write-back triple (wb_data, wb_addr, wb_en) along with zero/carry flags.
//
//   ADD/SUB/AND/OR/XOR          : one cycle, result registered at the accept edge
//   SLL/SRL by k = b[2:0]       : one bit per cycle, k cycles in RUN (k=0 is single-cycle)
//   MUL                         : 8-step shift-add, low byte of the product written back
//
// Ports
//   clk      in   1  clock, all state updates on the rising edge
//   rst_n    in   1  synchronous active-low reset
//   start    in   1  issue request, honoured only while busy=0
//   op       in   3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL
//   a        in   8  operand A
//   b        in   8  operand B, b[2:0] is the shift amount for SLL/SRL
//   rd       in   3  destination register address
//   busy     out  1  multi-cycle operation in flight
//   wb_en    out  1  one-cycle write strobe (suppressed when rd=0)
//   wb_addr  out  3  destination address, valid with wb_en
//   wb_data  out  8  result, valid with wb_en
//   flag_z   out  1  last written-back result was zero
//   flag_c   out  1  carry / borrow / last shifted-out bit / MUL overflow
//
// FSM states
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; single-cycle ops complete here
//   ST_RUN   | iterating a shift or multiply; busy=1, counter runs down to 1
// -----------------------------------------------------------------------------
module exec_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] rd,
    output logic       busy,
    output logic       wb_en,
    output logic [2:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       flag_z,
    output logic       flag_c
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [3:0]  cnt_q;        // remaining RUN steps, write-back when it reads 1
    logic [2:0]  op_q;
    logic [2:0]  rd_q;
    logic [7:0]  shreg_q;      // value being shifted for SLL/SRL
    logic [15:0] mcand_q;      // multiplicand, widened so it can shift left 7 times
    logic [7:0]  mplier_q;     // multiplier, consumed LSB first
    logic [15:0] acc_q;        // product accumulator

    // Registered outputs
    logic        busy_q;
    logic        wb_en_q;
    logic [2:0]  wb_addr_q;
    logic [7:0]  wb_data_q;
    logic        flag_z_q;
    logic        flag_c_q;

    // ------------------------------------------------------------------
    // Accept-cycle combinational result (single-cycle path)
    // ------------------------------------------------------------------
    logic [7:0]  alu_res_d;
    logic        alu_c_d;
    logic        multi_d;      // accepted op needs the RUN state

    always_comb begin
        alu_res_d = 8'h00;
        alu_c_d   = 1'b0;
        multi_d   = 1'b0;
        case (op)
            // 9-bit add: bit 8 is the carry out of bit 7
            OP_ADD: {alu_c_d, alu_res_d} = {1'b0, a} + {1'b0, b};
            // 9-bit subtract: bit 8 goes high exactly when a < b (borrow)
            OP_SUB: {alu_c_d, alu_res_d} = {1'b0, a} - {1'b0, b};
            OP_AND: alu_res_d = a & b;
            OP_OR:  alu_res_d = a | b;
            OP_XOR: alu_res_d = a ^ b;
            // A zero-length shift is a plain pass-through with no carry
            OP_SLL, OP_SRL: begin
                alu_res_d = a;
                multi_d   = (b[2:0] != 3'd0);
            end
            OP_MUL: multi_d = 1'b1;
            default: begin
                alu_res_d = 8'h00;
                alu_c_d   = 1'b0;
                multi_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RUN-state step logic
    // ------------------------------------------------------------------
    logic [7:0]  shift_val_d;
    logic        shift_out_d;
    logic [15:0] acc_d;
    logic [7:0]  run_res_d;
    logic        run_c_d;
    logic        last_step_d;

    always_comb begin
        shift_val_d = 8'h00;
        shift_out_d = 1'b0;
        if (op_q == OP_SLL) begin
            shift_val_d = {shreg_q[6:0], 1'b0};
            shift_out_d = shreg_q[7];
        end else begin
            shift_val_d = {1'b0, shreg_q[7:1]};
            shift_out_d = shreg_q[0];
        end

        acc_d = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

        run_res_d = 8'h00;
        run_c_d   = 1'b0;
        if (op_q == OP_MUL) begin
            run_res_d = acc_d[7:0];
            run_c_d   = (acc_d[15:8] != 8'h00);
        end else begin
            run_res_d = shift_val_d;
            run_c_d   = shift_out_d;
        end

        last_step_d = (cnt_q == 4'd1);
    end

    // ------------------------------------------------------------------
    // Controller: state, datapath registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_q      <= OP_ADD;
            rd_q      <= 3'd0;
            shreg_q   <= 8'h00;
            mcand_q   <= 16'h0000;
            mplier_q  <= 8'h00;
            acc_q     <= 16'h0000;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 3'd0;
            wb_data_q <= 8'h00;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse; it is only raised below
            wb_en_q <= 1'b0;

            if (state_q == ST_IDLE) begin
                if (start) begin
                    op_q <= op;
                    rd_q <= rd;
                    if (multi_d) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= (op == OP_MUL) ? 4'd8 : {1'b0, b[2:0]};
                        shreg_q  <= a;
                        mcand_q  <= {8'h00, a};
                        mplier_q <= b;
                        acc_q    <= 16'h0000;
                    end else begin
                        wb_en_q   <= (rd != 3'd0);
                        wb_addr_q <= rd;
                        wb_data_q <= alu_res_d;
                        flag_z_q  <= (alu_res_d == 8'h00);
                        flag_c_q  <= alu_c_d;
                    end
                end
            end else begin
                // start is deliberately ignored here and not queued
                cnt_q <= cnt_q - 4'd1;
                if (op_q == OP_MUL) begin
                    acc_q    <= acc_d;
                    mcand_q  <= {mcand_q[14:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[7:1]};
                end else begin
                    shreg_q <= shift_val_d;
                end

                // busy drops in the write-back cycle so a new op can be
                // accepted while the strobe is high
                if (last_step_d) begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    wb_en_q   <= (rd_q != 3'd0);
                    wb_addr_q <= rd_q;
                    wb_data_q <= run_res_d;
                    flag_z_q  <= (run_res_d == 8'h00);
                    flag_c_q  <= run_c_d;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;

endmodule
